// File: rtl/controle_blackjack.sv
// Blackjack game-flow controller: sequences the deal, the player and dealer turns
// over a four-phase card-request handshake with the scoring block, then latches the result.
module controle_blackjack #(
  parameter int unsigned LIMITE_DEALER = 17,
  parameter int unsigned BLACKJACK     = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       hit,
  input  logic       stay,
  input  logic       cartaok,
  input  logic [5:0] pts_jogador,
  input  logic [5:0] pts_dealer,
  output logic       pjogador,
  output logic       pdealer,
  output logic       limpa,
  output logic       vitoria,
  output logic       derrota,
  output logic       empate,
  output logic       fim_jogo
);

  typedef enum logic [2:0] {
    OCIOSO, LIMPA, REQ, LIBERA, VEZ_JOG, VEZ_DEALER, RESULTADO, FIM
  } estado_t;

  // Who the pending card is for: deal alternation, a player hit, or a dealer draw.
  typedef enum logic [1:0] {
    CTX_DEAL, CTX_JOG, CTX_DEALER
  } contexto_t;

  localparam logic [5:0] LIM = 6'(LIMITE_DEALER);
  localparam logic [5:0] BJ  = 6'(BLACKJACK);

  estado_t   estado;
  contexto_t ctx;
  logic [1:0] cnt;
  logic iniciar_ant, hit_ant, stay_ant;
  logic ini_ev, hit_ev, stay_ev;
  logic sel_jog;

  assign ini_ev  = iniciar & ~iniciar_ant;
  assign hit_ev  = hit & ~hit_ant;
  assign stay_ev = stay & ~stay_ant;

  always_comb begin
    sel_jog = 1'b0;
    case (ctx)
      CTX_DEAL: sel_jog = ~cnt[0];
      CTX_JOG:  sel_jog = 1'b1;
      default:  sel_jog = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= OCIOSO;
      ctx         <= CTX_DEAL;
      cnt         <= '0;
      iniciar_ant <= 1'b0;
      hit_ant     <= 1'b0;
      stay_ant    <= 1'b0;
      pjogador    <= 1'b0;
      pdealer     <= 1'b0;
      limpa       <= 1'b0;
      vitoria     <= 1'b0;
      derrota     <= 1'b0;
      empate      <= 1'b0;
      fim_jogo    <= 1'b0;
    end else begin
      iniciar_ant <= iniciar;
      hit_ant     <= hit;
      stay_ant    <= stay;
      limpa       <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (ini_ev) estado <= LIMPA;
        end
        LIMPA: begin
          limpa  <= 1'b1;
          cnt    <= '0;
          ctx    <= CTX_DEAL;
          estado <= REQ;
        end
        REQ: begin
          // Acknowledge is only honoured once our own request is actually on the wire.
          if (cartaok && (pjogador || pdealer)) begin
            pjogador <= 1'b0;
            pdealer  <= 1'b0;
            estado   <= LIBERA;
          end else begin
            pjogador <= sel_jog;
            pdealer  <= ~sel_jog;
          end
        end
        LIBERA: begin
          if (!cartaok) begin
            case (ctx)
              CTX_DEAL: begin
                if (cnt != 2'd3) begin
                  cnt    <= cnt + 2'd1;
                  estado <= REQ;
                end else if (pts_jogador == BJ) begin
                  ctx    <= CTX_DEALER;
                  estado <= VEZ_DEALER;
                end else begin
                  estado <= VEZ_JOG;
                end
              end
              CTX_JOG: begin
                if (pts_jogador > BJ) estado <= RESULTADO;
                else                  estado <= VEZ_JOG;
              end
              default: estado <= VEZ_DEALER;
            endcase
          end
        end
        VEZ_JOG: begin
          if (stay_ev) begin
            ctx    <= CTX_DEALER;
            estado <= VEZ_DEALER;
          end else if (hit_ev) begin
            ctx    <= CTX_JOG;
            estado <= REQ;
          end
        end
        VEZ_DEALER: begin
          if (pts_dealer < LIM) begin
            ctx    <= CTX_DEALER;
            estado <= REQ;
          end else begin
            estado <= RESULTADO;
          end
        end
        RESULTADO: begin
          if (pts_jogador > BJ) begin
            derrota <= 1'b1;
          end else if (pts_dealer > BJ) begin
            vitoria <= 1'b1;
          end else if (pts_jogador > pts_dealer) begin
            vitoria <= 1'b1;
          end else if (pts_jogador < pts_dealer) begin
            derrota <= 1'b1;
          end else begin
            empate <= 1'b1;
          end
          fim_jogo <= 1'b1;
          estado   <= FIM;
        end
        FIM: begin
          if (ini_ev) begin
            vitoria  <= 1'b0;
            derrota  <= 1'b0;
            empate   <= 1'b0;
            fim_jogo <= 1'b0;
            estado   <= LIMPA;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_blackjack.sv
// Scoreboard bench for controle_blackjack: a card-dealing responder stub, a game-level
// reference model feeding an expected-event queue, and a monitor that pops on DUT events.
module tb_controle_blackjack;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, iniciar, hit, stay, cartaok;
  logic [5:0] pts_jogador, pts_dealer;
  logic pjogador, pdealer, limpa, vitoria, derrota, empate, fim_jogo;

  controle_blackjack #(.LIMITE_DEALER(17), .BLACKJACK(21)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .hit(hit), .stay(stay),
    .cartaok(cartaok), .pts_jogador(pts_jogador), .pts_dealer(pts_dealer),
    .pjogador(pjogador), .pdealer(pdealer), .limpa(limpa), .vitoria(vitoria),
    .derrota(derrota), .empate(empate), .fim_jogo(fim_jogo)
  );

  // Event codes: 0 limpa, 1 player request, 2 dealer request, 3 win, 4 loss, 5 tie, 9 illegal.
  int compared = 0;
  int mismatched = 0;
  int exp_q[$];
  int deck_q[$];
  int game_deck[$];
  int n_done = 0;
  bit sb_en = 1'b0;
  int cyc = 0;
  int last_ev = -1;
  int limpa_cyc = 0;
  logic p_limpa = 1'b0, p_pj = 1'b0, p_pd = 1'b0, p_fim = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic ev_check(input string nm, input int act);
    int e;
    if (exp_q.size() == 0) e = -1;
    else e = exp_q.pop_front();
    chk(nm, act, e);
    last_ev = act;
  endtask

  // Responder stub: acknowledge 5 cycles after a request, drop 2 cycles after it falls.
  initial begin
    int v;
    bit who, ok;
    cartaok = 1'b0;
    pts_jogador = '0;
    pts_dealer = '0;
    forever begin
      @(negedge clock);
      if (limpa) begin
        pts_jogador = '0;
        pts_dealer = '0;
      end
      if ((pjogador || pdealer) && !cartaok) begin
        who = pjogador;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          if (!(pjogador || pdealer)) ok = 1'b0;
        end
        if (ok) begin
          v = (deck_q.size() != 0) ? deck_q.pop_front() : 2;
          if (who) pts_jogador = pts_jogador + 6'(v);
          else     pts_dealer  = pts_dealer + 6'(v);
          cartaok = 1'b1;
          for (int g = 0; g < 100 && (pjogador || pdealer); g++) @(negedge clock);
          repeat (2) @(negedge clock);
          cartaok = 1'b0;
          n_done++;
        end
      end
    end
  end

  // Monitor: every rising output event pops one expected event.
  always @(negedge clock) begin
    int a;
    cyc++;
    if (sb_en) begin
      if (limpa && !p_limpa) begin
        ev_check("limpa_pulse", 0);
        limpa_cyc = cyc;
      end
      if ((pjogador && !p_pj) || (pdealer && !p_pd)) begin
        a = (pjogador && !pdealer) ? 1 : (pdealer && !pjogador) ? 2 : 9;
        if (last_ev == 0) chk("limpa_to_first_request_gap", cyc - limpa_cyc, 1);
        ev_check("card_request", a);
      end
      if (fim_jogo && !p_fim) begin
        case ({vitoria, derrota, empate})
          3'b100:  a = 3;
          3'b010:  a = 4;
          3'b001:  a = 5;
          default: a = 9;
        endcase
        ev_check("game_result", a);
      end
    end
    p_limpa = limpa;
    p_pj = pjogador;
    p_pd = pdealer;
    p_fim = fim_jogo;
  end

  task automatic press(input bit h, input bit s, input bit i, input int len);
    @(negedge clock);
    hit = h;
    stay = s;
    iniciar = i;
    repeat (len) @(negedge clock);
    hit = 1'b0;
    stay = 1'b0;
    iniciar = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_done(input int target);
    for (int t = 0; t < 500 && n_done < target; t++) @(negedge clock);
    chk("handshake_completed", int'(n_done >= target), 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic pad_deck();
    while (game_deck.size() < 16) game_deck.push_back(2);
  endtask

  // Reference model plays the game from the deck with plain blackjack arithmetic,
  // then the driver presses the buttons the plan calls for.
  task automatic run_game(input int nh, input bit hold, input bit both);
    int p, d, k, hd, base;
    bit nat, bust;
    pad_deck();
    p = game_deck[0] + game_deck[2];
    d = game_deck[1] + game_deck[3];
    k = 4;
    hd = 0;
    bust = 1'b0;
    nat = (p == 21);
    exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2);
    if (!nat && !both) begin
      for (int h = 0; h < nh && !bust; h++) begin
        exp_q.push_back(1);
        p += game_deck[k];
        k++;
        hd++;
        if (p > 21) bust = 1'b1;
      end
    end
    if (!bust) begin
      while (d < 17) begin
        exp_q.push_back(2);
        d += game_deck[k];
        k++;
      end
    end
    if (bust || p > 21)      exp_q.push_back(4);
    else if (d > 21)         exp_q.push_back(3);
    else if (p > d)          exp_q.push_back(3);
    else if (p < d)          exp_q.push_back(4);
    else                     exp_q.push_back(5);

    deck_q = game_deck;
    base = n_done;
    press(1'b0, 1'b0, 1'b1, 2);
    wait_done(base + 4);
    if (nat) begin
      press(1'b1, 1'b0, 1'b0, 2);
    end else begin
      press(1'b0, 1'b0, 1'b1, 2);
      if (both) begin
        press(1'b1, 1'b1, 1'b0, 2);
      end else begin
        for (int h = 0; h < hd; h++) begin
          press(1'b1, 1'b0, 1'b0, (hold && h == 0) ? 20 : 2);
          wait_done(base + 5 + h);
        end
        if (!bust) press(1'b0, 1'b1, 1'b0, 2);
      end
    end
    for (int t = 0; t < 3000 && !fim_jogo; t++) @(negedge clock);
    chk("fim_jogo_reached", int'(fim_jogo), 1);
    repeat (3) @(negedge clock);
    chk("expected_events_consumed", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    hit = 1'b0;
    stay = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", int'({pjogador, pdealer, limpa, vitoria, derrota, empate, fim_jogo}), 0);
    reset = 1'b0;
    sb_en = 1'b1;
    @(negedge clock);

    game_deck = '{10, 9, 7, 8};          run_game(0, 1'b0, 1'b0);
    game_deck = '{10, 9, 6, 8, 9};       run_game(1, 1'b0, 1'b0);
    game_deck = '{10, 6, 8, 5, 3, 10};   run_game(0, 1'b0, 1'b0);
    game_deck = '{11, 10, 10, 7};        run_game(0, 1'b0, 1'b0);
    game_deck = '{10, 5, 3, 9, 2};       run_game(1, 1'b1, 1'b0);
    game_deck = '{10, 9, 5, 6};          run_game(1, 1'b0, 1'b1);
    game_deck = '{40, 9, 20, 8};         run_game(0, 1'b0, 1'b0);
    game_deck = '{10, 30, 9, 33};        run_game(0, 1'b0, 1'b0);

    for (int g = 0; g < 12; g++) begin
      game_deck.delete();
      for (int c = 0; c < 16; c++) game_deck.push_back(int'($urandom_range(2, 11)));
      run_game(int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // Reset while a player request is on the wire.
    sb_en = 1'b0;
    press(1'b0, 1'b0, 1'b1, 2);
    for (int t = 0; t < 50 && !pjogador; t++) @(negedge clock);
    chk("request_before_reset", int'(pjogador), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_mid_handshake", int'({pjogador, pdealer, limpa, vitoria, derrota, empate, fim_jogo}), 0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    exp_q.delete();
    last_ev = -1;
    sb_en = 1'b1;
    game_deck = '{10, 9, 7, 8};          run_game(0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
